shrinker_final_reduce: RTL and testbench
========================================

Name: shrinker_final_reduce

Overview:
- Downstream consumer of each Shrinker round output once `done` is high.
- Takes the carry-save pair (p, q) and the modulus n.
- Computes S = p + q in binary, digit-serially, W bits per cycle.
- Repeatedly subtracts n, digit-serially, until S < n, then returns the binary residue over a valid/ready handshake.
- Bridges the redundant-form modmul datapath to the binary result interface.

Parameters:
- N, 512, modulus width; p and q are N+1 bits.
- W, 64, digit width per cycle; N % W == 0 is required.
- MAX_SUB, 4, maximum successful subtractions before the overflow flag is set.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  p, q and n are valid.
- in_ready  output  1  block can accept an operand.
- p  input  N+1  carry-save sum word.
- q  input  N+1  carry-save carry word.
- n  input  N  modulus; n > 0.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  N  (p+q) mod n, or a partial value when overflow=1.
- overflow  output  1  reduction did not finish within MAX_SUB+1 passes.

Behaviour:
- One clock domain; reset is synchronous and active-low. With rst_n=0 at a clk edge:
  - state←IDLE; in_ready=1; out_valid=0; result=0; overflow=0.
  - All internal registers are cleared.
  - This applies mid-operation too: the in-flight operand is discarded and no output is produced.
- Digit count: K=N/W. Internal operands are zero-extended to (K+1)*W bits. A pass means K+1 cycles, processing digit 0 (LSB) first.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, p, q and n are latched (accept edge E0). Carry is cleared, digit index=0, sub_count=0, state←ADD.
- State ADD (K+1 cycles):
  - Each edge: S[d] = p[d] + q[d] + carry, carry updated, index++.
  - After digit K: state←SUB, index=0, borrow=0.
- State SUB (K+1 cycles per pass):
  - Each edge: D[d] = S[d] − n[d] − borrow, borrow updated. S is not modified during the pass.
  - At the final digit with borrow_out=0 (S ≥ n): S←D, sub_count++.
    - If sub_count now equals MAX_SUB+1: state←DONE, overflow=1.
    - Otherwise start a new SUB pass.
  - At the final digit with borrow_out=1 (S < n): state←DONE, overflow=0.
- State DONE:
  - out_valid=1; result=S[N-1:0].
  - When overflow=1, result is the low N bits of S after the last subtraction.
  - result and overflow are held stable until out_ready=1 at an edge; then state←IDLE and out_valid←0.
  - Backpressure is unbounded.
- in_ready=1 only in IDLE. No new operand is accepted in DONE, even when out_ready=1 in the same cycle.
- Latency: with m successful subtractions (m ≤ MAX_SUB), out_valid rises after edge E0 + (K+1)(m+2).
- Arithmetic:
  - S is N+2 bits wide (max 2^(N+2)−2); D has the same width.
  - n is zero-extended.
  - Carry and borrow are single bits, registered between digits.
- Inputs are don't-care outside the accept edge. n is never re-sampled during an operation.

Decomposition:
- Package shrinker_pkg:
  - state encoding (IDLE, ADD, SUB, DONE);
  - localparam K=N/W;
  - a digit-slice helper function;
  - the MAX_SUB counter width, $clog2(MAX_SUB+2).
- One sub-module, shrinker_digit_addsub: combinational W-bit add/subtract with carry/borrow in and out, selected by a mode bit. Used for both ADD and SUB passes.
- The top level holds the FSM, the digit index counter, the S/D/n registers and the handshake.

Test Plan:
- Config for all cases: N=8, W=4, MAX_SUB=4, so K=2 and 3 cycles per pass.
- No subtraction: p=0x064, q=0x032, n=0xB5 → result=0x96, overflow=0, out_valid rises 6 edges after accept.
- Two subtractions: p=0x0FF, q=0x0FF, n=0xB5 → result=0x94 (510−2·181), overflow=0, latency 12 edges.
- Overflow: p=0x1FF, q=0x1FF, n=0x01 → 5 successful passes, overflow=1, result=0xF9 (1017 mod 256), latency 18 edges.
- Backpressure: same as case 1 with out_ready=0 for 10 cycles → result=0x96 held stable, in_ready=0 throughout. One cycle of out_ready=1 → out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-operation: rst_n=0 for one edge during the second SUB pass of case 2 → the next cycle shows out_valid=0, in_ready=1, result=0, overflow=0. A fresh case-1 operand then yields 0x96 with nominal latency.

Source files
------------

// File: rtl/shrinker_pkg.sv
// Shared types and helpers for the carry-save to binary final reduction block.
// Default sizing, state encoding and digit/counter sizing helpers.
package shrinker_pkg;

  localparam int unsigned SHR_N       = 512;
  localparam int unsigned SHR_W       = 64;
  localparam int unsigned SHR_MAX_SUB = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_SUB,
    ST_DONE
  } state_e;

  function automatic int unsigned num_digits(input int unsigned n, input int unsigned w);
    return n / w;
  endfunction

  // Bit offset of digit idx inside a digit-serial word.
  function automatic int unsigned digit_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

  function automatic int unsigned sub_cnt_width(input int unsigned max_sub);
    return $clog2(max_sub + 2);
  endfunction

  localparam int unsigned K         = num_digits(SHR_N, SHR_W);
  localparam int unsigned SUB_CNT_W = sub_cnt_width(SHR_MAX_SUB);

endpackage

// File: rtl/shrinker_digit_addsub.sv
// One W-bit digit of add (carry) or subtract (borrow), shared by the ADD and SUB passes.
module shrinker_digit_addsub #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] y,
  output logic         cout
);

  logic [W:0] sum;

  // In subtract mode the top bit of the W+1-bit difference is the borrow out.
  always_comb begin
    if (sub) sum = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
    else     sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

  assign y    = sum[W-1:0];
  assign cout = sum[W];

endmodule

// File: rtl/shrinker_final_reduce.sv
// Digit-serial S = p + q followed by repeated S - n passes until S < n,
// returning the binary residue over a valid/ready handshake.
module shrinker_final_reduce
  import shrinker_pkg::*;
#(
  parameter int unsigned N       = SHR_N,
  parameter int unsigned W       = SHR_W,
  parameter int unsigned MAX_SUB = SHR_MAX_SUB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N:0]   p,
  input  logic [N:0]   q,
  input  logic [N-1:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow
);

  localparam int unsigned NDIG = num_digits(N, W);
  localparam int unsigned XW   = (NDIG + 1) * W;
  localparam int unsigned IW   = (NDIG + 1 > 1) ? $clog2(NDIG + 1) : 1;
  localparam int unsigned CW   = sub_cnt_width(MAX_SUB);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NDIG);
  localparam logic [CW-1:0] SUB_LIMIT = CW'(MAX_SUB + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   p_q, p_d, q_q, q_d, n_q, n_d, s_q, s_d, d_q, d_d;
  logic [N-1:0]    result_q, result_d;
  logic            overflow_q, overflow_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  logic [W-1:0]    op_a, op_b, dig_y;
  logic            op_sub, dig_co;
  int unsigned     lsb;

  assign lsb = digit_lsb(32'(idx_q), W);

  shrinker_digit_addsub #(.W(W)) u_digit (
    .a    (op_a),
    .b    (op_b),
    .cin  (cy_q),
    .sub  (op_sub),
    .y    (dig_y),
    .cout (dig_co)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cy_d        = cy_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    q_d         = q_q;
    n_d         = n_q;
    s_d         = s_q;
    d_d         = d_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    op_sub      = (state_q == ST_SUB);
    op_a        = op_sub ? s_q[lsb +: W] : p_q[lsb +: W];
    op_b        = op_sub ? n_q[lsb +: W] : q_q[lsb +: W];

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          p_d        = XW'(p);
          q_d        = XW'(q);
          n_d        = XW'(n);
          s_d        = '0;
          d_d        = '0;
          cy_d       = 1'b0;
          idx_d      = '0;
          cnt_d      = '0;
          overflow_d = 1'b0;
          in_ready_d = 1'b0;
          state_d    = ST_ADD;
        end
      end
      ST_ADD: begin
        s_d[lsb +: W] = dig_y;
        cy_d          = dig_co;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cy_d    = 1'b0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        d_d[lsb +: W] = dig_y;
        cy_d          = dig_co;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          cy_d  = 1'b0;
          if (!dig_co) begin
            // S >= n: commit the difference, then either run another pass or give up.
            s_d   = d_d;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == SUB_LIMIT) begin
              state_d     = ST_DONE;
              overflow_d  = 1'b1;
              result_d    = s_d[N-1:0];
              out_valid_d = 1'b1;
            end
          end else begin
            state_d     = ST_DONE;
            overflow_d  = 1'b0;
            result_d    = s_q[N-1:0];
            out_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      n_q         <= '0;
      s_q         <= '0;
      d_q         <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cy_q        <= cy_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      q_q         <= q_d;
      n_q         <= n_d;
      s_q         <= s_d;
      d_q         <= d_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_shrinker_final_reduce.sv
// Directed scoreboard bench for shrinker_final_reduce with N=8, W=4, MAX_SUB=4.
module tb_shrinker_final_reduce;

  localparam int unsigned N = 8;
  localparam int unsigned W = 4;
  localparam int unsigned MAX_SUB = 4;
  localparam int TIMEOUT = 200;

  typedef struct {
    logic [N-1:0] res;
    logic         ovf;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N:0]   p;
  logic [N:0]   q;
  logic [N-1:0] n;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         overflow;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  shrinker_final_reduce #(.N(N), .W(W), .MAX_SUB(MAX_SUB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .q         (q),
    .n         (n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_result"},    32'(result),    32'd0);
    check({tag, "_overflow"},  32'(overflow),  32'd0);
  endtask

  // Push the expectation, present the operand and return just after the accept edge.
  task automatic send(input logic [N:0] pv, input logic [N:0] qv, input logic [N-1:0] nv,
                      input logic [N-1:0] res, input logic ovf, input int lat);
    exp_t e;
    int   waited;
    e.res = res;
    e.ovf = ovf;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    p        = pv;
    q        = qv;
    n        = nv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    p        = '1;
    q        = '1;
    n        = '1;
    check("busy_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Count edges after accept until out_valid, then compare against the scoreboard head.
  task automatic wait_result(input string tag);
    exp_t e;
    int   lat;
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"},   32'(result),   32'(e.res));
      check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
      check({tag, "_latency"},  32'(lat),      32'(e.lat));
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    p         = '0;
    q         = '0;
    n         = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    send(9'h064, 9'h032, 8'hB5, 8'h96, 1'b0, 6);
    wait_result("no_sub");
    consume("no_sub");

    send(9'h0FF, 9'h0FF, 8'hB5, 8'h94, 1'b0, 12);
    wait_result("two_sub");
    consume("two_sub");

    send(9'h1FF, 9'h1FF, 8'h01, 8'hF9, 1'b1, 18);
    wait_result("ovf");
    consume("ovf");

    // Backpressure with a competing operand presented while DONE.
    send(9'h064, 9'h032, 8'hB5, 8'h96, 1'b0, 6);
    wait_result("bp");
    @(negedge clk);
    in_valid = 1'b1;
    p        = 9'h011;
    q        = 9'h022;
    n        = 8'h05;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_result", 32'(result),    32'h96);
      check("bp_hold_valid",  32'(out_valid), 32'd1);
      check("bp_hold_ready",  32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_drain_valid", 32'(out_valid), 32'd0);
    check("bp_drain_ready", 32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    check("bp_no_accept", 32'(in_ready), 32'd1);

    // Reset during the second SUB pass; the pending expectation is discarded.
    send(9'h0FF, 9'h0FF, 8'hB5, 8'h94, 1'b0, 12);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_idle("midreset");
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_no_output", 32'(out_valid), 32'd0);

    send(9'h064, 9'h032, 8'hB5, 8'h96, 1'b0, 6);
    wait_result("after_reset");
    consume("after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
